tick_slot_scheduler: RTL and testbench

- Round-robin scheduler that shares the periodic tick strobe from the clock divider among N_REQ requesters.
- Grants one requester exclusive ownership of the tick stream for up to SLOT_TICKS ticks.
- The owner ends its slot with done, or by dropping req; otherwise the slot ends on expiry.
- Sits between the divider's 1-cycle enable output and slow peripherals (display scan, button sampling, UART pacing) that must not run concurrently.

---
 rtl/tick_slot_scheduler.sv | 98 +++++++++
 tb/tb_tick_slot_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tick_slot_scheduler.sv
// tick_slot_scheduler: round-robin time-slot owner of a shared divider tick strobe.
module tick_slot_scheduler #(
  parameter int N_REQ      = 4,
  parameter int SLOT_TICKS = 3,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(SLOT_TICKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             owner_tick,
  output logic             slot_start,
  output logic             slot_timeout,
  output logic             busy
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d, ptr_q, ptr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic slot_start_q, slot_start_d, slot_timeout_q, slot_timeout_d, busy_q, busy_d;
  logic rel_early, expire;
  int j;
  // Scan downward so the lowest circular offset from ptr is the last to win.
  always_comb begin
    win = '0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) win = IW'(j);
    end
  end
  assign rel_early = !req[grant_id_q] || done[grant_id_q];
  assign expire    = tick && cnt_q == CW'(1);
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    slot_start_d   = 1'b0;
    slot_timeout_d = 1'b0;
    case (state_q)
      IDLE: if (tick && |req) begin
        state_d      = OWN;
        grant_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win;
        grant_id_d   = win;
        busy_d       = 1'b1;
        slot_start_d = 1'b1;
        cnt_d        = CW'(SLOT_TICKS);
        ptr_d        = win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
      end
      OWN: if (rel_early || expire) begin
        state_d        = IDLE;
        grant_d        = '0;
        busy_d         = 1'b0;
        cnt_d          = '0;
        slot_timeout_d = !rel_early;
      end else if (tick) begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      grant_id_q     <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      slot_start_q   <= 1'b0;
      slot_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      slot_start_q   <= slot_start_d;
      slot_timeout_q <= slot_timeout_d;
    end
  end
  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign slot_start   = slot_start_q;
  assign slot_timeout = slot_timeout_q;
  assign owner_tick   = tick & busy_q;
endmodule

// File: tb/tb_tick_slot_scheduler.sv
// tb_tick_slot_scheduler: directed checks of arbitration, slot ending and reset.
module tb_tick_slot_scheduler;
  logic clk = 1'b0;
  logic reset, tick;
  logic [3:0] req, done, grant;
  logic [1:0] grant_id, exp_id;
  logic owner_tick, slot_start, slot_timeout, busy;
  int checks = 0, failures = 0;
  int ot_cnt = 0, ss_cnt = 0, to_cnt = 0, oh_err = 0;

  tick_slot_scheduler #(.N_REQ(4), .SLOT_TICKS(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .owner_tick(owner_tick),
    .slot_start(slot_start), .slot_timeout(slot_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock cycle with tick=t; owner_tick sampled mid-cycle, registered outputs after the edge.
  task automatic cyc(input logic t);
    tick = t;
    #1;
    if (owner_tick) ot_cnt++;
    @(posedge clk);
    #1;
    if (slot_start) ss_cnt++;
    if (slot_timeout) to_cnt++;
    if (!$onehot0(grant)) oh_err++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) cyc(1'b0);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (slot_start !== 1'b0 || slot_timeout !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", slot_start, slot_timeout); end
    reset = 1'b0;
  endtask

  task automatic test_single_slot;
    ot_cnt = 0; ss_cnt = 0; to_cnt = 0;
    req = 4'b0100;
    cyc(1'b0);
    cyc(1'b1);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
    checks++; if (busy !== 1'b1 || slot_start !== 1'b1) begin failures++; $display("FAIL single_start got busy=%b start=%b exp=1,1", busy, slot_start); end
    checks++; if (ot_cnt != 0) begin failures++; $display("FAIL single_arb_tick_fwd got=%0d exp=0", ot_cnt); end
    cyc(1'b0);
    checks++; if (slot_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", slot_start); end
    repeat (3) cyc(1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      if (k < 2) repeat (4) cyc(1'b0);
    end
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_expire got grant=%b busy=%b exp=0000,0", grant, busy); end
    checks++; if (slot_timeout !== 1'b1) begin failures++; $display("FAIL single_timeout got=%b exp=1", slot_timeout); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_id_kept got=%0d exp=2", grant_id); end
    checks++; if (ot_cnt != 3 || ss_cnt != 1) begin failures++; $display("FAIL single_counts got ot=%0d ss=%0d exp=3,1", ot_cnt, ss_cnt); end
    cyc(1'b0);
    checks++; if (slot_timeout !== 1'b0 || to_cnt != 1) begin failures++; $display("FAIL single_timeout_pulse got=%b cnt=%0d exp=0,1", slot_timeout, to_cnt); end
    req = 4'b1001;
    repeat (2) cyc(1'b0);
    cyc(1'b1);
    checks++; if (grant !== 4'b1000 || grant_id !== 2'd3) begin failures++; $display("FAIL single_ptr3 got grant=%b id=%0d exp=1000,3", grant, grant_id); end
    req = 4'b0000;
    cyc(1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_cleanup got busy=%b exp=0", busy); end
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    oh_err = 0;
    for (int s = 0; s < 8; s++) begin
      exp_id = s[1:0];
      repeat (4) cyc(1'b0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_tick slot=%0d got busy=%b exp=0", s, busy); end
      ot_cnt = 0;
      cyc(1'b1);
      checks++; if (grant_id !== exp_id || grant !== (4'b0001 << exp_id)) begin failures++; $display("FAIL rr_order slot=%0d got id=%0d grant=%b exp id=%0d", s, grant_id, grant, exp_id); end
      repeat (3) begin
        repeat (4) cyc(1'b0);
        cyc(1'b1);
      end
      checks++; if (slot_timeout !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rr_expire slot=%0d got to=%b busy=%b exp=1,0", s, slot_timeout, busy); end
      checks++; if (ot_cnt != 3) begin failures++; $display("FAIL rr_owner_ticks slot=%0d got=%0d exp=3", s, ot_cnt); end
    end
    checks++; if (oh_err != 0) begin failures++; $display("FAIL rr_onehot got=%0d exp=0", oh_err); end
    req = 4'b0000;
  endtask

  task automatic test_done;
    req = 4'b0010;
    cyc(1'b0);
    cyc(1'b1);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL done_grant got=%b exp=0010", grant); end
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    done = 4'b1000;
    cyc(1'b0);
    done = 4'b0000;
    checks++; if (busy !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL done_nonowner got grant=%b busy=%b exp=0010,1", grant, busy); end
    to_cnt = 0;
    done = 4'b0010;
    cyc(1'b0);
    done = 4'b0000;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL done_release got grant=%b busy=%b exp=0000,0", grant, busy); end
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL done_id_kept got=%0d exp=1", grant_id); end
    cyc(1'b0);
    checks++; if (to_cnt != 0) begin failures++; $display("FAIL done_no_timeout got=%0d exp=0", to_cnt); end
    req = 4'b0000;
  endtask

  task automatic test_done_on_expiry;
    req = 4'b0100;
    ot_cnt = 0; to_cnt = 0;
    cyc(1'b1);
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL coinc_grant got=%b exp=0100", grant); end
    repeat (2) begin
      repeat (4) cyc(1'b0);
      cyc(1'b1);
    end
    repeat (4) cyc(1'b0);
    done = 4'b0100;
    cyc(1'b1);
    done = 4'b0000;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL coinc_release got grant=%b busy=%b exp=0000,0", grant, busy); end
    cyc(1'b0);
    checks++; if (to_cnt != 0) begin failures++; $display("FAIL coinc_no_timeout got=%0d exp=0", to_cnt); end
    checks++; if (ot_cnt != 3) begin failures++; $display("FAIL coinc_owner_ticks got=%0d exp=3", ot_cnt); end
    req = 4'b0000;
  endtask

  task automatic test_abandon;
    req = 4'b1000;
    cyc(1'b1);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL aband_grant got=%b exp=1000", grant); end
    repeat (2) cyc(1'b0);
    req = 4'b0000;
    cyc(1'b0);
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || slot_timeout !== 1'b0) begin failures++; $display("FAIL aband_release got grant=%b busy=%b to=%b exp=0000,0,0", grant, busy, slot_timeout); end
    cyc(1'b0);
    cyc(1'b1);
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || slot_start !== 1'b0) begin failures++; $display("FAIL aband_tick_noreq got grant=%b busy=%b start=%b exp=0000,0,0", grant, busy, slot_start); end
  endtask

  task automatic test_reset_mid_slot;
    req = 4'b0100;
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin failures++; $display("FAIL rmid_pre got busy=%b id=%0d exp=1,2", busy, grant_id); end
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    checks++; if (grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_outputs got grant=%b id=%0d busy=%b exp=0000,0,0", grant, grant_id, busy); end
    checks++; if (slot_start !== 1'b0 || slot_timeout !== 1'b0) begin failures++; $display("FAIL rmid_pulses got=%b%b exp=00", slot_start, slot_timeout); end
    req = 4'b1010;
    cyc(1'b0);
    cyc(1'b1);
    checks++; if (grant !== 4'b0010 || grant_id !== 2'd1) begin failures++; $display("FAIL rmid_ptr got grant=%b id=%0d exp=0010,1", grant, grant_id); end
    req = 4'b0000;
    cyc(1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; req = 4'b0000; done = 4'b0000;
    test_reset;
    test_single_slot;
    test_round_robin;
    test_done;
    test_done_on_expiry;
    test_abandon;
    test_reset_mid_slot;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
